// File: rtl/text_console_writer_if.sv
// ============================================================================
// text_console_writer_if
// Character stream, clear request, text-buffer write bus and cursor status.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface text_console_writer_if;
    logic        ch_valid;
    logic [7:0]  ch_data;
    logic        ch_ready;
    logic        clr;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;
    logic [4:0]  cur_row;
    logic [6:0]  cur_col;
    logic        busy;

    // slave: the console writer; master: character source / buffer observer
    modport slave (
        input  ch_valid, ch_data, clr,
        output ch_ready, wr_en, wr_addr, wr_data, cur_row, cur_col, busy
    );

    modport master (
        output ch_valid, ch_data, clr,
        input  ch_ready, wr_en, wr_addr, wr_data, cur_row, cur_col, busy
    );
endinterface

`default_nettype wire

// File: rtl/text_console_writer.sv
// ============================================================================
// text_console_writer
// Turns a character stream into text-buffer writes with cursor, CR/LF/BS
// handling, wrap-around row clearing and full-screen clear.
// Revision: 1.0
// ============================================================================
`default_nettype none

module text_console_writer #(
    parameter int         COLS  = 80,
    parameter int         ROWS  = 25,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    text_console_writer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CLEAR_ROW = 2'd1,
        CLEAR_ALL = 2'd2
    } state_t;

    localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
    localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
    localparam logic [10:0] ROW_END   = 11'(COLS - 1);
    localparam logic [10:0] SCR_END   = 11'(COLS * ROWS - 1);

    state_t      state_q, state_d;
    logic [4:0]  row_q, row_d;
    logic [6:0]  col_q, col_d;
    logic [10:0] cnt_q, cnt_d;
    logic        wr_en_q, wr_en_d;
    logic [10:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        adv_row;
    logic        accept;
    logic [10:0] cur_addr;

    assign cur_addr = 11'(row_q) * 11'(COLS) + 11'(col_q);
    assign accept   = (state_q == IDLE) && !bus.clr && bus.ch_valid;

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        adv_row   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.clr) begin
                    state_d = CLEAR_ALL;
                    row_d   = 5'd0;
                    col_d   = 7'd0;
                    cnt_d   = 11'd0;
                end else if (accept) begin
                    if (bus.ch_data >= 8'h20 && bus.ch_data <= 8'h7E) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = cur_addr;
                        wr_data_d = bus.ch_data;
                        if (col_q == LAST_COL) begin
                            col_d   = 7'd0;
                            adv_row = 1'b1;
                        end else begin
                            col_d = col_q + 7'd1;
                        end
                    end else if (bus.ch_data == 8'h0A) begin
                        col_d   = 7'd0;
                        adv_row = 1'b1;
                    end else if (bus.ch_data == 8'h0D) begin
                        col_d = 7'd0;
                    end else if (bus.ch_data == 8'h08 && col_q != 7'd0) begin
                        col_d     = col_q - 7'd1;
                        wr_en_d   = 1'b1;
                        wr_addr_d = cur_addr - 11'd1;
                        wr_data_d = BLANK;
                    end
                end
            end
            CLEAR_ROW: begin
                if (bus.clr) begin
                    state_d = CLEAR_ALL;
                    row_d   = 5'd0;
                    col_d   = 7'd0;
                    cnt_d   = 11'd0;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q;
                    wr_data_d = BLANK;
                    if (cnt_q == ROW_END) state_d = IDLE;
                    else                  cnt_d   = cnt_q + 11'd1;
                end
            end
            CLEAR_ALL: begin
                wr_en_d   = 1'b1;
                wr_addr_d = cnt_q;
                wr_data_d = BLANK;
                if (cnt_q == SCR_END) state_d = IDLE;
                else                  cnt_d   = cnt_q + 11'd1;
            end
            default: state_d = IDLE;
        endcase

        // Wrapping past the bottom row scrolls to the top and blanks row 0.
        if (adv_row) begin
            if (row_q == LAST_ROW) begin
                row_d   = 5'd0;
                state_d = CLEAR_ROW;
                cnt_d   = 11'd0;
            end else begin
                row_d = row_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            row_q     <= 5'd0;
            col_q     <= 7'd0;
            cnt_q     <= 11'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 11'd0;
            wr_data_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.ch_ready = (state_q == IDLE) && !bus.clr;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.cur_row  = row_q;
    assign bus.cur_col  = col_q;
    assign bus.busy     = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_text_console_writer.sv
// ============================================================================
// tb_text_console_writer
// Directed self-checking bench for text_console_writer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_text_console_writer;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    text_console_writer_if bus ();

    text_console_writer #(
        .COLS  (80),
        .ROWS  (25),
        .BLANK (8'h20)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Starts and ends on a falling edge; outputs of the accepting edge are visible on return.
    task automatic send(input logic [7:0] c);
        bus.ch_valid = 1'b1;
        bus.ch_data  = c;
        @(posedge clk);
        @(negedge clk);
        bus.ch_valid = 1'b0;
    endtask

    task automatic cursor_is(input string tag, input int row, input int col);
        check({tag, "_row"}, 32'(bus.cur_row), 32'(row));
        check({tag, "_col"}, 32'(bus.cur_col), 32'(col));
    endtask

    // Follows a clear sequence: every write must be BLANK at the next ascending address.
    task automatic watch_clear(input int limit, output int n_busy, output int n_wr,
                               output int n_bad, output int done);
        n_busy = 0;
        n_wr   = 0;
        n_bad  = 0;
        done   = 0;
        for (int i = 0; i < limit; i++) begin
            if (bus.busy) n_busy++;
            if (bus.busy && bus.ch_ready) n_bad++;
            if (bus.wr_en) begin
                if (bus.wr_addr != 11'(n_wr) || bus.wr_data != 8'h20) n_bad++;
                n_wr++;
            end
            if (!bus.busy && !bus.wr_en) begin
                done = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int nb, nw, bad, done, found, stray;
        n_checks     = 0;
        n_errors     = 0;
        rst_n        = 1'b0;
        bus.ch_valid = 1'b0;
        bus.ch_data  = 8'h00;
        bus.clr      = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        check("rst_wr_data", 32'(bus.wr_data), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        cursor_is("rst", 0, 0);

        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(bus.ch_ready), 32'd1);

        send(8'h41);
        check("A_wr_en", 32'(bus.wr_en), 32'd1);
        check("A_wr_addr", 32'(bus.wr_addr), 32'd0);
        check("A_wr_data", 32'(bus.wr_data), 32'h41);
        cursor_is("A", 0, 1);

        send(8'h07);
        check("bel_no_wr", 32'(bus.wr_en), 32'd0);
        cursor_is("bel", 0, 1);
        send(8'h7F);
        check("del_no_wr", 32'(bus.wr_en), 32'd0);
        check("del_hold_addr", 32'(bus.wr_addr), 32'd0);
        cursor_is("del", 0, 1);

        send(8'h0D);
        check("cr_no_wr", 32'(bus.wr_en), 32'd0);
        cursor_is("cr", 0, 0);

        send(8'h0A);
        send(8'h0A);
        cursor_is("lf2", 2, 0);
        send(8'h08);
        check("bs_col0_no_wr", 32'(bus.wr_en), 32'd0);
        cursor_is("bs_col0", 2, 0);

        for (int i = 0; i < 5; i++) send(8'h61);
        cursor_is("five", 2, 5);
        send(8'h08);
        check("bs_wr_en", 32'(bus.wr_en), 32'd1);
        check("bs_wr_addr", 32'(bus.wr_addr), 32'd164);
        check("bs_wr_data", 32'(bus.wr_data), 32'h20);
        cursor_is("bs", 2, 4);

        send(8'h0A);
        for (int i = 0; i < 79; i++) send(8'h78);
        cursor_is("r3c79", 3, 79);
        send(8'h42);
        check("wrap_wr_en", 32'(bus.wr_en), 32'd1);
        check("wrap_wr_addr", 32'(bus.wr_addr), 32'd319);
        check("wrap_wr_data", 32'(bus.wr_data), 32'h42);
        cursor_is("wrap", 4, 0);

        for (int i = 0; i < 20; i++) send(8'h0A);
        for (int i = 0; i < 10; i++) send(8'h79);
        cursor_is("r24c10", 24, 10);
        send(8'h0A);
        cursor_is("scroll", 0, 0);
        check("scroll_busy", 32'(bus.busy), 32'd1);
        check("scroll_ready", 32'(bus.ch_ready), 32'd0);
        watch_clear(300, nb, nw, bad, done);
        check("row_done", 32'(done), 32'd1);
        check("row_busy_cycles", 32'(nb), 32'd80);
        check("row_writes", 32'(nw), 32'd80);
        check("row_order", 32'(bad), 32'd0);
        check("row_ready_after", 32'(bus.ch_ready), 32'd1);

        send(8'h70);
        send(8'h71);
        cursor_is("pre_clr", 0, 2);

        bus.clr      = 1'b1;
        bus.ch_valid = 1'b1;
        bus.ch_data  = 8'h5A;
        #1;
        check("clr_ready_low", 32'(bus.ch_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.clr      = 1'b0;
        bus.ch_valid = 1'b0;
        cursor_is("clr", 0, 0);
        check("clr_busy", 32'(bus.busy), 32'd1);
        watch_clear(2100, nb, nw, bad, done);
        check("all_done", 32'(done), 32'd1);
        check("all_busy_cycles", 32'(nb), 32'd2000);
        check("all_writes", 32'(nw), 32'd2000);
        check("all_order", 32'(bad), 32'd0);
        cursor_is("all_end", 0, 0);

        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        found = 0;
        for (int i = 0; i < 1000; i++) begin
            if (bus.wr_en && bus.wr_addr == 11'd500) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("reach_500", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_wr_en", 32'(bus.wr_en), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_wr_addr", 32'(bus.wr_addr), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.wr_en || bus.busy) stray++;
        end
        check("no_resume", 32'(stray), 32'd0);
        send(8'h43);
        check("post_rst_wr_en", 32'(bus.wr_en), 32'd1);
        check("post_rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        check("post_rst_wr_data", 32'(bus.wr_data), 32'h43);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/text_console_writer.md
TEXT_CONSOLE_WRITER -- requirements
Module: text_console_writer

Interface
REQ-001 SHALL have parameter COLS, default 80, meaning characters per row.
REQ-002 SHALL have parameter ROWS, default 25, meaning rows per screen.
REQ-003 SHALL have parameter BLANK, default 8'h20, meaning fill code used for clears and backspace.
REQ-004 SHALL have port clk, input, 1, system clock; all logic on the rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port ch_valid, input, 1, meaning the source offers a character.
REQ-007 SHALL have port ch_data, input, 8, meaning the offered character code.
REQ-008 SHALL have port ch_ready, output, 1, meaning the block accepts a character this cycle.
REQ-009 SHALL have port clr, input, 1, a single-cycle clear-screen request.
REQ-010 SHALL have port wr_en, output, 1, the text buffer write strobe.
REQ-011 SHALL have port wr_addr, output, 11, the buffer address, row*COLS+col, range 0..1999.
REQ-012 SHALL have port wr_data, output, 8, the character code to write.
REQ-013 SHALL have port cur_row, output, 5, the cursor row, 0..ROWS-1.
REQ-014 SHALL have port cur_col, output, 7, the cursor column, 0..COLS-1.
REQ-015 SHALL have port busy, output, 1, high while any clear sequence runs.

Function
REQ-016 SHALL implement FSM states IDLE, CLEAR_ROW and CLEAR_ALL; ch_ready SHALL be 1 only in IDLE with clr low.
REQ-017 SHALL define acceptance as ch_valid && ch_ready at a rising edge; ch_data SHALL be sampled only at that edge.
REQ-018 SHALL, for an accepted printable code (0x20..0x7E), register wr_en=1, wr_addr=cur_row*COLS+cur_col and wr_data=ch_data, visible one cycle after acceptance.
REQ-019 SHALL, after a printable write, advance cur_col by 1; when cur_col=COLS-1, set cur_col=0 and advance the row per REQ-022.
REQ-020 SHALL, for 0x0A (LF), set cur_col=0 and advance the row per REQ-022, with no write.
REQ-021 SHALL, for 0x0D (CR), set cur_col=0, leaving cur_row unchanged, with no write.
REQ-022 SHALL advance the row as follows: if cur_row<ROWS-1, increment cur_row; if cur_row=ROWS-1, set cur_row=0 and enter CLEAR_ROW for row 0.
REQ-023 SHALL, for 0x08 (BS) with cur_col>0, decrement cur_col and write BLANK at the new position; with cur_col=0, do nothing.
REQ-024 SHALL consume all other codes (0x00..0x1F except 0x08, 0x0A and 0x0D, plus 0x7F..0xFF) with no write and no cursor change.
REQ-025 SHALL, in CLEAR_ROW, write BLANK to addresses r*COLS..r*COLS+COLS-1, one per cycle, in ascending order, then return to IDLE; this is exactly COLS write cycles.
REQ-026 SHALL, when clr=1 is sampled in IDLE, enter CLEAR_ALL, set the cursor to (0,0) and discard any simultaneous ch_valid; clr takes priority.
REQ-027 SHALL, in CLEAR_ALL, write BLANK to addresses 0..COLS*ROWS-1, one per cycle, then return to IDLE; this is exactly 2000 write cycles.
REQ-028 SHALL, when clr=1 is sampled during CLEAR_ROW, abort that row clear and restart as CLEAR_ALL from address 0 on the next cycle.
REQ-029 SHALL ignore clr during CLEAR_ALL.
REQ-030 SHALL drive wr_en=0 in every cycle that carries no write; wr_addr and wr_data SHALL hold their last value while wr_en=0.
REQ-031 SHALL drive busy=1 in CLEAR_ROW and CLEAR_ALL and busy=0 in IDLE.
REQ-032 SHALL never drive wr_addr to a value at or above COLS*ROWS.

Reset
REQ-033 SHALL, while rst_n=0, asynchronously force: state=IDLE, cur_row=0, cur_col=0, wr_en=0, wr_addr=0, wr_data=0, busy=0.
REQ-034 SHALL drive ch_ready=1 in the first cycle after rst_n deasserts.
REQ-035 SHALL, on reset during CLEAR_ROW or CLEAR_ALL, abandon the sequence immediately, issue no further writes, and not resume the clear after release.

Verification
REQ-036 SHALL cover this scenario: after reset, send 'A' (0x41) -> next cycle wr_en=1, wr_addr=0, wr_data=0x41, and cursor=(0,1).
REQ-037 SHALL cover this scenario: place the cursor at (3,79) and send 0x42 -> write to address 319, then cursor=(4,0).
REQ-038 SHALL cover this scenario: place the cursor at (24,10) and send 0x0A -> cursor=(0,0), busy=1 for 80 cycles with writes of 0x20 to addresses 0..79 in order, ch_ready=0 throughout, then back to IDLE.
REQ-039 SHALL cover this scenario: clr pulse together with ch_valid=1 in IDLE -> character dropped, 2000 writes to addresses 0..1999, cursor=(0,0).
REQ-040 SHALL cover this scenario: cursor at (2,0) with 0x08 -> no write; cursor at (2,5) with 0x08 -> cursor=(2,4) and 0x20 written to address 164.
REQ-041 SHALL cover this scenario: rst_n asserted mid-CLEAR_ALL at address 500 -> wr_en=0 immediately, and after release no write occurs until a new character is accepted.
